// File: rtl/gpu_pixel_writer_if.sv
// Pixel-in / framebuffer-write bus of the pixel writer.
// No latency of its own: it only bundles the signals.
// Backpressure: ready_o throttles pixels, mem_ack_i throttles write requests.
interface gpu_pixel_writer_if #(
    parameter int unsigned X_BITS     = 10,
    parameter int unsigned Y_BITS     = 9,
    parameter int unsigned ADDR_BITS  = 19,
    parameter int unsigned COLOR_BITS = 24
);
    logic                  pix_valid_i;
    logic [X_BITS-1:0]     x_i;
    logic [Y_BITS-1:0]     y_i;
    logic [COLOR_BITS-1:0] color_i;
    logic                  ready_o;
    logic                  mem_req_o;
    logic [ADDR_BITS-1:0]  mem_addr_o;
    logic [COLOR_BITS-1:0] mem_data_o;
    logic                  mem_ack_i;
    logic                  idle_o;
    logic                  overflow_o;
    logic                  clipped_o;

    modport slave (
        input  pix_valid_i, x_i, y_i, color_i, mem_ack_i,
        output ready_o, mem_req_o, mem_addr_o, mem_data_o, idle_o, overflow_o, clipped_o
    );

    modport master (
        output pix_valid_i, x_i, y_i, color_i, mem_ack_i,
        input  ready_o, mem_req_o, mem_addr_o, mem_data_o, idle_o, overflow_o, clipped_o
    );
endinterface

// File: rtl/gpu_pixel_writer.sv
// Queues (x,y,color) pixels and issues framebuffer write requests; GPU_PIXEL_CLIP_EN drops off-screen pixels.
// Latency: pixel accepted at edge E into an empty queue raises mem_req_o at E+1; 1 pixel/cycle with ack held.
// Backpressure: ready_o low while the queue is full (or in reset); mem_req_o holds addr/data until mem_ack_i.
module gpu_pixel_writer #(
    parameter int unsigned X_BITS     = 10,
    parameter int unsigned Y_BITS     = 9,
    parameter int unsigned FB_WIDTH   = 640,
    parameter int unsigned FB_HEIGHT  = 480,
    parameter int unsigned ADDR_BITS  = 19,
    parameter int unsigned COLOR_BITS = 24,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    gpu_pixel_writer_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = ADDR_BITS + COLOR_BITS;
`ifdef GPU_PIXEL_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    typedef enum logic {IDLE, REQ} state_t;

    state_t                state, state_nxt;
    logic [ENT_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  in_reset;
    logic                  ready;
    logic                  accept;
    logic                  off_screen;
    logic                  push;
    logic                  pop;
    logic                  overflow;
    logic                  clipped;
    logic [ADDR_BITS-1:0]  pix_addr;
    logic [ADDR_BITS-1:0]  mem_addr;
    logic [COLOR_BITS-1:0] mem_data;

    // Row-major address, wrapping silently at ADDR_BITS for off-screen coordinates.
    assign pix_addr   = ADDR_BITS'(bus.y_i) * ADDR_BITS'(FB_WIDTH) + ADDR_BITS'(bus.x_i);
    assign off_screen = (32'(bus.x_i) >= FB_WIDTH) || (32'(bus.y_i) >= FB_HEIGHT);
    assign ready      = !in_reset && (count < CNT_W'(FIFO_DEPTH));
    assign accept     = bus.pix_valid_i && ready;
    assign push       = accept && !(CLIP_EN && off_screen);

    // Hold ready low through the reset window and release it on the first edge after.
    always_ff @(posedge clk) begin
        in_reset <= rst;
    end

    // Queue storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {pix_addr, bus.color_i};
        end
    end

    // Queue pointers and occupancy; push and pop in the same cycle cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and pop: load the head when idle, or on an ack to keep requests back-to-back.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.mem_ack_i) begin
                    if (count != '0) pop = 1'b1;
                    else             state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request address/data: loaded on pop, otherwise held (including while idle).
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr <= '0;
            mem_data <= '0;
        end else if (pop) begin
            {mem_addr, mem_data} <= fifo_mem[rd_ptr];
        end
    end

    // Sticky overflow and single-cycle clip pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            clipped  <= 1'b0;
        end else begin
            overflow <= overflow || (bus.pix_valid_i && !ready);
            clipped  <= CLIP_EN && accept && off_screen;
        end
    end

    assign bus.ready_o    = ready;
    assign bus.mem_req_o  = (state == REQ);
    assign bus.mem_addr_o = mem_addr;
    assign bus.mem_data_o = mem_data;
    assign bus.idle_o     = (count == '0) && (state == IDLE);
    assign bus.overflow_o = overflow;
    assign bus.clipped_o  = clipped;
endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Directed bench for gpu_pixel_writer with a write scoreboard.
// Expected writes are queued as pixels are driven and matched on each req/ack handshake.
// Honours GPU_PIXEL_CLIP_EN for the off-screen pixel case.
module tb_gpu_pixel_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   wr_count = 0;
    logic [42:0] sb [$];

    gpu_pixel_writer_if bus ();

    gpu_pixel_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one pixel for one edge; check ready beforehand and optionally queue the expected write.
    task automatic send(input int x, input int y, input logic [23:0] c,
                        input bit exp_rdy, input bit exp_push);
        logic [18:0] a;
        bus.pix_valid_i = 1'b1;
        bus.x_i         = 10'(x);
        bus.y_i         = 9'(y);
        bus.color_i     = c;
        @(negedge clk);
        chk("ready", 64'(bus.ready_o), 64'(exp_rdy));
        if (exp_push) begin
            a = 19'(y * 640 + x);
            sb.push_back({a, c});
        end
        @(posedge clk);
        #1;
        bus.pix_valid_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write monitor: a handshake completes on the next edge when req and ack are both high.
    always @(negedge clk) begin
        logic [42:0] e;
        if (!rst && bus.mem_req_o && bus.mem_ack_i) begin
            wr_count++;
            chk("wr_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", 64'(bus.mem_addr_o), 64'(e[42:24]));
                chk("wr_data", 64'(bus.mem_data_o), 64'(e[23:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.pix_valid_i = 1'b0;
        bus.x_i         = '0;
        bus.y_i         = '0;
        bus.color_i     = '0;
        bus.mem_ack_i   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req",      64'(bus.mem_req_o),  64'd0);
        chk("rst_addr",     64'(bus.mem_addr_o), 64'd0);
        chk("rst_data",     64'(bus.mem_data_o), 64'd0);
        chk("rst_overflow", 64'(bus.overflow_o), 64'd0);
        chk("rst_clipped",  64'(bus.clipped_o),  64'd0);
        chk("rst_idle",     64'(bus.idle_o),     64'd1);
        chk("rst_ready",    64'(bus.ready_o),    64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("ready_after_rst", 64'(bus.ready_o), 64'd1);
        tick();

        // Single pixel, ack held high
        bus.mem_ack_i = 1'b1;
        send(5, 2, 24'hFF0000, 1'b1, 1'b1);
        @(negedge clk);
        chk("single_req_e", 64'(bus.mem_req_o), 64'd0);
        tick();
        @(negedge clk);
        chk("single_req_e1", 64'(bus.mem_req_o),  64'd1);
        chk("single_addr",   64'(bus.mem_addr_o), 64'd1285);
        chk("single_data",   64'(bus.mem_data_o), 64'hFF0000);
        tick();
        @(negedge clk);
        chk("single_req_drop", 64'(bus.mem_req_o), 64'd0);
        chk("single_idle",     64'(bus.idle_o),    64'd1);
        chk("single_hold",     64'(bus.mem_addr_o), 64'd1285);

        // Burst of 6 with ack low: 5 accepted, 6th overflows
        tick();
        bus.mem_ack_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(10 + i, 3, 24'(32'h100 + i), i < 5, i < 5);
        end
        @(negedge clk);
        chk("burst_overflow", 64'(bus.overflow_o), 64'd1);
        chk("burst_ready",    64'(bus.ready_o),    64'd0);
        chk("burst_req",      64'(bus.mem_req_o),  64'd1);
        tick();
        bus.mem_ack_i = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        chk("burst_drained", 64'(sb.size()), 64'd0);
        repeat (2) tick();
        @(negedge clk);
        chk("burst_idle", 64'(bus.idle_o), 64'd1);
        tick();

        // Back-to-back row boundary pixels, ack held high
        n = wr_count;
        send(0,   0, 24'h000001, 1'b1, 1'b1);
        send(639, 0, 24'h000002, 1'b1, 1'b1);
        send(0,   1, 24'h000003, 1'b1, 1'b1);
        chk("b2b_first_done", 64'(wr_count - n), 64'd1);
        @(negedge clk);
        chk("b2b_req1",  64'(bus.mem_req_o),  64'd1);
        chk("b2b_addr1", 64'(bus.mem_addr_o), 64'd639);
        tick();
        @(negedge clk);
        chk("b2b_req2",  64'(bus.mem_req_o),  64'd1);
        chk("b2b_addr2", 64'(bus.mem_addr_o), 64'd640);
        tick();
        @(negedge clk);
        chk("b2b_req_drop", 64'(bus.mem_req_o), 64'd0);
        chk("b2b_count",    64'(wr_count - n),  64'd3);
        tick();

        // Reset while in REQ with 3 queued pixels; late ack must be ignored
        bus.mem_ack_i = 1'b0;
        for (int i = 0; i < 4; i++) send(20 + i, 7, 24'h00AA00, 1'b1, 1'b0);
        @(negedge clk);
        chk("pre_rst_req", 64'(bus.mem_req_o), 64'd1);
        tick();
        rst           = 1'b1;
        bus.mem_ack_i = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_req_drop", 64'(bus.mem_req_o),  64'd0);
        chk("rst_req_idle", 64'(bus.idle_o),     64'd1);
        chk("rst_req_ovf",  64'(bus.overflow_o), 64'd0);
        tick();
        rst = 1'b0;
        n   = wr_count;
        repeat (10) tick();
        @(negedge clk);
        chk("post_rst_no_wr", 64'(wr_count - n), 64'd0);
        chk("post_rst_idle",  64'(bus.idle_o),   64'd1);
        chk("post_rst_ready", 64'(bus.ready_o),  64'd1);
        tick();

        // Off-screen pixel (700,10)
        n = wr_count;
`ifdef GPU_PIXEL_CLIP_EN
        send(700, 10, 24'h123456, 1'b1, 1'b0);
        @(negedge clk);
        chk("clip_pulse", 64'(bus.clipped_o), 64'd1);
        tick();
        @(negedge clk);
        chk("clip_pulse_end", 64'(bus.clipped_o), 64'd0);
        repeat (4) tick();
        chk("clip_no_wr", 64'(wr_count - n), 64'd0);
`else
        send(700, 10, 24'h123456, 1'b1, 1'b1);
        @(negedge clk);
        chk("noclip_pulse", 64'(bus.clipped_o), 64'd0);
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("noclip_wr", 64'(wr_count - n), 64'd1);
`endif
        repeat (2) tick();
        @(negedge clk);
        chk("final_idle", 64'(bus.idle_o), 64'd1);
        chk("sb_empty_end", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
